// File: rtl/axi_pkg.sv
// Shared AXI3 read-side constants, arbiter FSM states and AR payload type.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_SIZE_W = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_SIZE_W-1:0] size;
  } ar_req_t;

endpackage

// File: rtl/rd_prio_picker.sv
// Data-priority pick between the two refill ports, with an instruction starvation guard.
module rd_prio_picker
  import axi_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned STREAK_W     = 3
) (
  input  logic [1:0]          req,
  input  logic [STREAK_W-1:0] streak,
  output logic                winner,
  output logic                grant_valid
);

  logic inst_starved;

  always_comb begin
    inst_starved = req[PORT_INST] && (streak >= STREAK_W'(MAX_D_STREAK));
    grant_valid  = |req;
    winner       = (req[PORT_DATA] && !inst_starved) ? PORT_DATA : PORT_INST;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI3 read arbiter: one outstanding burst, owner tagged on arid, R routed back by owner.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [1:0]          m_req,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [15:0]         m_len,
  input  logic [5:0]          m_size,
  output logic [1:0]          m_addr_ok,
  output logic [1:0]          m_rvalid,
  output logic                m_rlast,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_rerr,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                proto_err
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  rd_state_e           state_q, state_d;
  logic                owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  ar_req_t             ar_q, ar_d;
  logic                proto_err_q, proto_err_d;
  logic                winner, grant_valid, rid_ok;

  rd_prio_picker #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_picker (
    .req          (m_req),
    .streak       (streak_q),
    .winner       (winner),
    .grant_valid  (grant_valid)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= RD_IDLE;
      owner_q     <= PORT_INST;
      streak_q    <= '0;
      ar_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      ar_q        <= ar_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    ar_d        = ar_q;
    proto_err_d = proto_err_q;
    m_addr_ok   = 2'b00;
    m_rvalid    = 2'b00;
    arvalid     = 1'b0;
    rready      = 1'b0;
    rid_ok      = (rid == {3'b000, owner_q});

    unique case (state_q)
      RD_IDLE: begin
        if (grant_valid) begin
          m_addr_ok[winner] = 1'b1;
          owner_d           = winner;
          ar_d.addr = AXI_ADDR_W'(winner ? m_addr[ADDR_W +: ADDR_W] : m_addr[0 +: ADDR_W]);
          ar_d.len  = winner ? m_len[8 +: 8] : m_len[0 +: 8];
          ar_d.size = winner ? m_size[3 +: 3] : m_size[0 +: 3];
          // Streak only grows while the instruction side is actually being passed over.
          if ((winner == PORT_DATA) && m_req[PORT_INST]) begin
            streak_d = (streak_q == STREAK_W'(MAX_D_STREAK)) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (rid_ok) m_rvalid[owner_q] = 1'b1;
          else        proto_err_d       = 1'b1;
          if (rlast) state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign m_rdata   = rdata;
  assign m_rlast   = rlast;
  assign m_rerr    = (rresp != AXI_RESP_OKAY);
  assign arid      = {3'b000, owner_q};
  assign araddr    = ADDR_W'(ar_q.addr);
  assign arlen     = ar_q.len;
  assign arsize    = ar_q.size;
  assign arburst   = AXI_BURST_INCR;
  assign arlock    = 2'b00;
  assign arcache   = 4'h0;
  assign arprot    = 3'h0;
  assign proto_err = proto_err_q;

endmodule
